// File: rtl/dht22_pkg.sv
// Shared constants for the DHT22 word-to-BCD converter: FSM encoding, limits,
// Fahrenheit scaling constants and the field positions of the sensor word.
package dht22_pkg;

  typedef enum logic [4:0] {
    ST_IDLE      = 5'b00001,
    ST_LOAD      = 5'b00010,
    ST_CONV_HUM  = 5'b00100,
    ST_CONV_TEMP = 5'b01000,
    ST_DONE      = 5'b10000
  } state_e;

  localparam int HUM_MAX  = 1000;
  localparam int TEMP_MAX = 800;
  localparam int BCD_SAT  = 9999;

  // f = F_OFS + ((s*F_MUL + F_RND) >>> F_SHR), s and f in 0.1 degree units
  localparam int F_MUL = 1843;
  localparam int F_RND = 512;
  localparam int F_SHR = 10;
  localparam int F_OFS = 320;

  localparam int HUM_MSB      = 31;
  localparam int HUM_LSB      = 16;
  localparam int TEMP_SIGN    = 15;
  localparam int TEMP_MAG_MSB = 14;

  function automatic logic [15:0] sat16(input logic [15:0] v, input logic [15:0] lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double dabble: 16-bit binary to 4 packed BCD digits, one bit per cycle.
// done is high during the 16th iteration; bcd carries that iteration's result.
module bin2bcd_seq (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] bin,
  output logic [15:0] bcd,
  output logic        done
);

  logic [31:0] sh;
  logic [31:0] nxt;
  logic [15:0] adj;
  logic [3:0]  cnt;
  logic        run;

  always_comb begin
    adj = '0;
    for (int i = 0; i < 4; i++)
      adj[4*i +: 4] = (sh[16 + 4*i +: 4] >= 4'd5) ? sh[16 + 4*i +: 4] + 4'd3
                                                   : sh[16 + 4*i +: 4];
    nxt = {adj[14:0], sh[15:0], 1'b0};
  end

  assign bcd  = nxt[31:16];
  assign done = run && (cnt == 4'd15);

  // start wins over a running iteration so the caller can chain conversions
  always_ff @(posedge sys_clk or negedge rst_n)
    if (!rst_n) begin
      sh  <= '0;
      cnt <= '0;
      run <= 1'b0;
    end else if (start) begin
      sh  <= {16'h0000, bin};
      cnt <= '0;
      run <= 1'b1;
    end else if (run) begin
      sh  <= nxt;
      cnt <= cnt + 4'd1;
      if (cnt == 4'd15) run <= 1'b0;
    end

endmodule

// File: rtl/dht22_bcd_convert.sv
// DHT22 word to sign + packed BCD with range flags; one shared double-dabble engine.
// Optional Fahrenheit output via `define DHT22_FAHRENHEIT_EN (range flags stay Celsius).
module dht22_bcd_convert #(
  parameter int HUM_MAX  = dht22_pkg::HUM_MAX,
  parameter int TEMP_MAX = dht22_pkg::TEMP_MAX,
  parameter int BCD_SAT  = dht22_pkg::BCD_SAT
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic [31:0] data_in,
  output logic [15:0] hum_bcd,
  output logic [15:0] temp_bcd,
  output logic        temp_neg,
  output logic        hum_err,
  output logic        temp_err,
  output logic        busy,
  output logic        done
);
  import dht22_pkg::*;

  localparam logic [15:0] SAT16 = 16'(BCD_SAT);

  state_e      state, state_nxt;
  logic [31:0] in_q, last_data;
  logic [15:0] hum_raw, temp_mag, hum_clamp, temp_clamp, temp_src;
  logic        temp_sgn, herr, terr;
  logic [15:0] sh_hum, sh_temp;
  logic        sh_neg, sh_herr, sh_terr;
  logic        eng_start, eng_done;
  logic [15:0] eng_bin, eng_bcd;

  assign hum_raw   = in_q[HUM_MSB:HUM_LSB];
  assign temp_mag  = {1'b0, in_q[TEMP_MAG_MSB:0]};
  assign hum_clamp = sat16(hum_raw, SAT16);
  assign herr      = hum_raw  > 16'(HUM_MAX);
  assign terr      = temp_mag > 16'(TEMP_MAX);

`ifdef DHT22_FAHRENHEIT_EN
  localparam logic signed [27:0] K_MUL = 28'(F_MUL);
  localparam logic signed [27:0] K_RND = 28'(F_RND);
  localparam logic signed [27:0] K_OFS = 28'(F_OFS);
  localparam logic signed [27:0] K_SAT = 28'(BCD_SAT);

  logic signed [27:0] s_c, f_val, f_mag;

  always_comb begin
    s_c = $signed({12'd0, temp_mag});
    if (in_q[TEMP_SIGN]) s_c = -s_c;
    f_val = K_OFS + ((s_c * K_MUL + K_RND) >>> F_SHR);
    f_mag = (f_val < 0) ? -f_val : f_val;
    temp_sgn   = f_val < 0;
    temp_clamp = (f_mag > K_SAT) ? SAT16 : f_mag[15:0];
  end
`else
  // a zero magnitude is never reported as negative
  assign temp_sgn   = in_q[TEMP_SIGN] && (temp_mag != 16'd0);
  assign temp_clamp = sat16(temp_mag, SAT16);
`endif

  bin2bcd_seq u_b2b (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .start   (eng_start),
    .bin     (eng_bin),
    .bcd     (eng_bcd),
    .done    (eng_done)
  );

  always_ff @(posedge sys_clk or negedge rst_n)
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;

  // humidity starts from LOAD; temperature is launched on the last humidity iteration
  always_comb begin
    state_nxt = state;
    eng_start = 1'b0;
    eng_bin   = hum_clamp;
    unique case (state)
      ST_IDLE:      if (in_q != last_data) state_nxt = ST_LOAD;
      ST_LOAD: begin
        eng_start = 1'b1;
        state_nxt = ST_CONV_HUM;
      end
      ST_CONV_HUM:  if (eng_done) begin
        eng_start = 1'b1;
        eng_bin   = temp_src;
        state_nxt = ST_CONV_TEMP;
      end
      ST_CONV_TEMP: if (eng_done) state_nxt = ST_DONE;
      ST_DONE:      state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  assign busy = (state != ST_IDLE);

  always_ff @(posedge sys_clk or negedge rst_n)
    if (!rst_n) begin
      in_q      <= '0;
      last_data <= '0;
      temp_src  <= '0;
      sh_hum    <= '0;
      sh_temp   <= '0;
      sh_neg    <= 1'b0;
      sh_herr   <= 1'b0;
      sh_terr   <= 1'b0;
      hum_bcd   <= '0;
      temp_bcd  <= '0;
      temp_neg  <= 1'b0;
      hum_err   <= 1'b0;
      temp_err  <= 1'b0;
      done      <= 1'b0;
    end else begin
      in_q <= data_in;
      done <= 1'b0;
      case (state)
        ST_LOAD: begin
          last_data <= in_q;
          temp_src  <= temp_clamp;
          sh_neg    <= temp_sgn;
          sh_herr   <= herr;
          sh_terr   <= terr;
        end
        ST_CONV_HUM:  if (eng_done) sh_hum  <= eng_bcd;
        ST_CONV_TEMP: if (eng_done) sh_temp <= eng_bcd;
        ST_DONE: begin
          hum_bcd  <= sh_hum;
          temp_bcd <= sh_temp;
          temp_neg <= sh_neg;
          hum_err  <= sh_herr;
          temp_err <= sh_terr;
          done     <= 1'b1;
        end
        default: ;
      endcase
    end

endmodule

// File: tb/tb_dht22_bcd_convert.sv
// Scoreboard bench for dht22_bcd_convert: directed words with hand-computed BCD results,
// checked by a monitor on every done pulse for value, arrival edge and busy length.
module tb_dht22_bcd_convert;

`ifdef DHT22_FAHRENHEIT_EN
  localparam bit FAHR = 1'b1;
`else
  localparam bit FAHR = 1'b0;
`endif

  typedef struct packed {
    logic [15:0] hum;
    logic [15:0] temp;
    logic        neg;
    logic        herr;
    logic        terr;
  } res_t;

  typedef struct {
    res_t r;
    int   at;
  } exp_t;

  logic        sys_clk = 1'b0;
  logic        rst_n   = 1'b0;
  logic [31:0] data_in = '0;
  logic [15:0] hum_bcd, temp_bcd;
  logic        temp_neg, hum_err, temp_err, busy, done;

  exp_t sb[$];
  int   cyc = 0;
  int   ncmp = 0;
  int   nmis = 0;
  int   n_done = 0;
  int   busy_cnt = 0;
  bit   prev_done = 1'b0;

  dht22_bcd_convert dut (
    .sys_clk  (sys_clk),
    .rst_n    (rst_n),
    .data_in  (data_in),
    .hum_bcd  (hum_bcd),
    .temp_bcd (temp_bcd),
    .temp_neg (temp_neg),
    .hum_err  (hum_err),
    .temp_err (temp_err),
    .busy     (busy),
    .done     (done)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // monitor: pops one expectation per done pulse
  always @(negedge sys_clk) begin
    exp_t e;
    res_t got;
    if (!rst_n) begin
      busy_cnt  = 0;
      prev_done = 1'b0;
    end else begin
      if (prev_done) begin
        ncmp++;
        if (done) begin
          nmis++;
          $display("FAIL done_width: done still high at edge %0d, required a 1-cycle pulse", cyc);
        end
      end
      if (busy) busy_cnt++;
      if (done) begin
        n_done++;
        if (sb.size() == 0) begin
          ncmp++; nmis++;
          $display("FAIL unexpected_done: done at edge %0d, no conversion expected", cyc);
        end else begin
          e   = sb.pop_front();
          got = '{hum_bcd, temp_bcd, temp_neg, hum_err, temp_err};
          ncmp++;
          if (got !== e.r) begin
            nmis++;
            $display("FAIL result: got hum=%h temp=%h neg=%b herr=%b terr=%b, required hum=%h temp=%h neg=%b herr=%b terr=%b",
                     got.hum, got.temp, got.neg, got.herr, got.terr,
                     e.r.hum, e.r.temp, e.r.neg, e.r.herr, e.r.terr);
          end
          ncmp++;
          if (cyc != e.at) begin
            nmis++;
            $display("FAIL done_edge: done at edge %0d, required edge %0d", cyc, e.at);
          end
          ncmp++;
          if (busy_cnt != 34) begin
            nmis++;
            $display("FAIL busy_len: busy for %0d cycles, required 34", busy_cnt);
          end
        end
        busy_cnt = 0;
      end
      prev_done = done;
    end
  end

  task automatic push(input res_t r, input int at);
    exp_t e;
    e.r  = r;
    e.at = at;
    sb.push_back(e);
  endtask

  // drives a new word; e0 is the edge that first samples it
  task automatic apply(input logic [31:0] d, output int e0);
    @(negedge sys_clk);
    data_in = d;
    e0 = cyc + 1;
  endtask

  task automatic drain();
    int i = 0;
    while (sb.size() != 0 && i < 300) begin
      @(posedge sys_clk);
      i++;
    end
    #1;
    ncmp++;
    if (sb.size() != 0) begin
      nmis++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
      sb.delete();
    end
    repeat (2) @(posedge sys_clk);
  endtask

  task automatic check_zero(input string name);
    ncmp++;
    if ({hum_bcd, temp_bcd, temp_neg, hum_err, temp_err, busy, done} !== '0) begin
      nmis++;
      $display("FAIL %s: hum=%h temp=%h neg=%b herr=%b terr=%b busy=%b done=%b, required all 0",
               name, hum_bcd, temp_bcd, temp_neg, hum_err, temp_err, busy, done);
    end
  endtask

  initial begin
    int e0, r0, nd;

    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    rst_n = 1'b1;
    @(posedge sys_clk); #1;
    check_zero("reset_state");
    repeat (40) @(posedge sys_clk); #1;
    check_zero("idle_zero_word");
    ncmp++;
    if (n_done != 0) begin
      nmis++;
      $display("FAIL idle_no_done: %0d done pulses, required 0", n_done);
    end

    // nominal
    apply({16'd652, 16'd253}, e0);
    push('{16'h0652, FAHR ? 16'h0775 : 16'h0253, 1'b0, 1'b0, 1'b0}, e0 + 35);
    drain();

    // humidity over range, negative temperature
    apply({16'd1050, 16'h8064}, e0);
    push('{16'h1050, FAHR ? 16'h0140 : 16'h0100, ~FAHR, 1'b1, 1'b0}, e0 + 35);
    drain();

    // change while busy: newest word follows one IDLE cycle plus 34 busy cycles
    apply({16'd450, 16'h8190}, e0);
    push('{16'h0450, 16'h0400, 1'b1, 1'b0, 1'b0}, e0 + 35);
    repeat (10) @(negedge sys_clk);
    data_in = {16'd700, 16'd300};
    push('{16'h0700, FAHR ? 16'h0860 : 16'h0300, 1'b0, 1'b0, 1'b0}, e0 + 70);
    drain();

    // change and revert while busy: exactly one conversion
    nd = n_done;
    apply({16'd0, 16'd250}, e0);
    push('{16'h0000, FAHR ? 16'h0770 : 16'h0250, 1'b0, 1'b0, 1'b0}, e0 + 35);
    repeat (5) @(negedge sys_clk);
    data_in = 32'hDEAD_BEEF;
    repeat (3) @(negedge sys_clk);
    data_in = {16'd0, 16'd250};
    drain();
    repeat (40) @(posedge sys_clk); #1;
    ncmp++;
    if (n_done - nd != 1) begin
      nmis++;
      $display("FAIL revert_single: %0d done pulses, required 1", n_done - nd);
    end

    // saturation
    apply({16'hFFFF, 16'h7FFF}, e0);
    push('{16'h9999, 16'h9999, 1'b0, 1'b1, 1'b1}, e0 + 35);
    drain();

    // negative zero, humidity exactly at limit
    apply({16'd1000, 16'h8000}, e0);
    push('{16'h1000, FAHR ? 16'h0320 : 16'h0000, 1'b0, 1'b0, 1'b0}, e0 + 35);
    drain();

    // both limits exactly, then one above
    apply({16'd1000, 16'd800}, e0);
    push('{16'h1000, FAHR ? 16'h1760 : 16'h0800, 1'b0, 1'b0, 1'b0}, e0 + 35);
    drain();
    apply({16'd1001, 16'd801}, e0);
    push('{16'h1001, FAHR ? 16'h1762 : 16'h0801, 1'b0, 1'b1, 1'b1}, e0 + 35);
    drain();

    // reset mid-conversion aborts; the same word converts again after release
    apply({16'd123, 16'd456}, e0);
    repeat (20) @(negedge sys_clk);
    #2 rst_n = 1'b0;
    #1 check_zero("reset_abort");
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    rst_n = 1'b1;
    r0 = cyc + 1;
    push('{16'h0123, FAHR ? 16'h1141 : 16'h0456, 1'b0, 1'b0, 1'b0}, r0 + 35);
    drain();

    repeat (40) @(posedge sys_clk); #1;
    ncmp++;
    if (sb.size() != 0) begin
      nmis++;
      $display("FAIL scoreboard_empty: %0d left, required 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nmis);
    $finish;
  end

endmodule
